apu_issue_queue: RTL and testbench

- Parametrised APU front-end between the CV32E40P APU port and the vector decoder/execute datapath.
- Buffers up to DEPTH accepted requests and presents them in order on a valid/ready issue interface.
- Tracks outstanding operations and returns exactly one registered apu_result/apu_rvalid per accepted request, in order.
- Result formatting (VL or vs2 element 0) is generalised over XLEN, VLEN and SEW, with sign-extension and error flags.

---
 rtl/apu_issue_queue_pkg.sv | 21 ++
 rtl/apu_issue_queue_if.sv | 32 +++
 rtl/apu_req_fifo.sv | 50 +++++
 rtl/apu_issue_queue.sv | 141 ++++++++++++++
 tb/tb_apu_issue_queue.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apu_issue_queue_pkg.sv
// Shared types and constants for the APU issue queue front-end.
package apu_issue_queue_pkg;

  // Source of the scalar value returned to the core on completion.
  typedef enum logic {
    APU_RESULT_SRC_VL    = 1'b0,
    APU_RESULT_SRC_VS2_0 = 1'b1
  } apu_result_src_t;

  // vsew encodings of the element width.
  localparam logic [1:0] SEW_8       = 2'd0;
  localparam logic [1:0] SEW_16      = 2'd1;
  localparam logic [1:0] SEW_32      = 2'd2;
  localparam logic [1:0] SEW_ILLEGAL = 2'd3;

  // Response flag layout.
  localparam int APU_FLAGS_O_W        = 5;
  localparam int APU_FLAG_ILLEGAL_SEW = 0;
  localparam int APU_FLAG_PROTO_ERR   = 1;

endpackage

// File: rtl/apu_issue_queue_if.sv
// CV32E40P-style APU request/response port.
interface apu_issue_queue_if
  import apu_issue_queue_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_OPERANDS = 3,
  parameter int OP_W         = 6,
  parameter int FLAGS_W      = 15
) ();

  logic                         apu_req;
  logic                         apu_gnt;
  logic [NUM_OPERANDS*XLEN-1:0] apu_operands_i;
  logic [OP_W-1:0]              apu_op;
  logic [FLAGS_W-1:0]           apu_flags_i;
  logic                         apu_rvalid;
  logic [XLEN-1:0]              apu_result;
  logic [APU_FLAGS_O_W-1:0]     apu_flags_o;

  // Core side drives requests and consumes responses.
  modport master (
    output apu_req, apu_operands_i, apu_op, apu_flags_i,
    input  apu_gnt, apu_rvalid, apu_result, apu_flags_o
  );

  // Queue side grants requests and produces responses.
  modport slave (
    input  apu_req, apu_operands_i, apu_op, apu_flags_i,
    output apu_gnt, apu_rvalid, apu_result, apu_flags_o
  );

endinterface

// File: rtl/apu_req_fifo.sv
// Synchronous FIFO with combinational head read; DEPTH must be a power of two.
module apu_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the index bits match.
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                    (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg[PTR_W-1:0]];

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
    end
  end

  // Pointer advance; natural overflow gives the modulo-DEPTH wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/apu_issue_queue.sv
// APU front-end: buffers requests, issues them in order and returns one
// formatted result per accepted request.
module apu_issue_queue
  import apu_issue_queue_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int XLEN         = 32,
  parameter int VLEN         = 128,
  parameter int NUM_OPERANDS = 3,
  parameter int OP_W         = 6,
  parameter int FLAGS_W      = 15,
  parameter int VL_W         = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  apu_issue_queue_if.slave             apu,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [NUM_OPERANDS*XLEN-1:0] issue_operands,
  output logic [OP_W-1:0]              issue_op,
  output logic [FLAGS_W-1:0]           issue_flags,
  input  logic                         done_i,
  input  logic                         result_sel_i,
  input  logic                         sign_ext_i,
  input  logic [VL_W-1:0]              vl_i,
  input  logic [1:0]                   vsew_i,
  input  logic [VLEN-1:0]              vs2_data_i
);

  localparam int OUT_W    = $clog2(DEPTH) + 1;
  localparam int ENTRY_W  = NUM_OPERANDS*XLEN + OP_W + FLAGS_W;
  localparam int SIGN_IDX = (XLEN < 32) ? XLEN - 1 : 31;

  logic [OUT_W-1:0]   outstanding_reg;
  logic [OUT_W-1:0]   outstanding_next;
  logic               rvalid_reg;
  logic [XLEN-1:0]    result_reg;
  logic [XLEN-1:0]    result_next;
  logic               illegal_reg;
  logic               proto_err_reg;
  logic               accept;
  logic               done_ok;
  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [XLEN-1:0]    vs2_raw;
  logic [XLEN-1:0]    elem0;
  logic               elem_sign;
  int                 elem_w;
  apu_result_src_t    result_src;
  logic               unused_vs2;

  // Grant depends only on the request and registered occupancy; reset masks it.
  assign apu.apu_gnt = apu.apu_req && !reset && (outstanding_reg < OUT_W'(DEPTH));
  assign accept      = apu.apu_req && apu.apu_gnt;
  assign done_ok     = done_i && (outstanding_reg != '0);
  // outstanding bounds occupancy, so the full guard never blocks an accept.
  assign fifo_push   = accept && !fifo_full;
  assign outstanding_next = outstanding_reg + OUT_W'(accept) - OUT_W'(done_ok);

  apu_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({apu.apu_operands_i, apu.apu_op, apu.apu_flags_i}),
    .pop       (issue_valid && issue_ready),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign issue_valid = !fifo_empty;
  assign {issue_operands, issue_op, issue_flags} = fifo_head;

  assign result_src = apu_result_src_t'(result_sel_i);
  assign vs2_raw    = vs2_data_i[XLEN-1:0];
  assign unused_vs2 = ^vs2_data_i;

  // Element 0 extraction: keep the low SEW bits, fill the rest with sign or zero.
  always_comb begin
    elem_w = 8 << vsew_i;
    case (vsew_i)
      SEW_8:   elem_sign = vs2_raw[7];
      SEW_16:  elem_sign = vs2_raw[15];
      default: elem_sign = vs2_raw[SIGN_IDX];
    endcase
    elem0 = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (i < elem_w) elem0[i] = vs2_raw[i];
      else            elem0[i] = sign_ext_i & elem_sign;
    end
  end

  // Select the response value; an illegal SEW always returns zero.
  always_comb begin
    result_next = '0;
    if (vsew_i == SEW_ILLEGAL) begin
      result_next = '0;
    end else if (result_src == APU_RESULT_SRC_VL) begin
      result_next = {{(XLEN-VL_W){1'b0}}, vl_i};
    end else begin
      result_next = elem0;
    end
  end

  // Occupancy tracking, response registers and sticky protocol error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_reg <= '0;
      rvalid_reg      <= 1'b0;
      result_reg      <= '0;
      illegal_reg     <= 1'b0;
      proto_err_reg   <= 1'b0;
    end else begin
      outstanding_reg <= outstanding_next;
      rvalid_reg      <= done_ok;
      if (done_ok) begin
        result_reg  <= result_next;
        illegal_reg <= (vsew_i == SEW_ILLEGAL);
      end
      if (done_i && (outstanding_reg == '0)) begin
        proto_err_reg <= 1'b1;
      end
    end
  end

  assign apu.apu_rvalid = rvalid_reg;
  assign apu.apu_result = result_reg;

  // Pack the response flags; unused bits read as zero.
  always_comb begin
    apu.apu_flags_o = '0;
    apu.apu_flags_o[APU_FLAG_ILLEGAL_SEW] = illegal_reg;
    apu.apu_flags_o[APU_FLAG_PROTO_ERR]   = proto_err_reg;
  end

endmodule

// File: tb/tb_apu_issue_queue.sv
// Self-checking bench for apu_issue_queue with issue and response scoreboards.
module tb_apu_issue_queue;

  localparam int DEPTH = 4;
  localparam int XLEN = 32;
  localparam int VLEN = 128;
  localparam int NOPS = 3;
  localparam int OP_W = 6;
  localparam int FW = 15;
  localparam int VL_W = 5;
  localparam int EW = NOPS*XLEN + OP_W + FW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic issue_valid, issue_ready;
  logic [NOPS*XLEN-1:0] issue_operands;
  logic [OP_W-1:0] issue_op;
  logic [FW-1:0] issue_flags;
  logic done_i, result_sel_i, sign_ext_i;
  logic [VL_W-1:0] vl_i;
  logic [1:0] vsew_i;
  logic [VLEN-1:0] vs2_data_i;

  int n_checks = 0;
  int n_fail = 0;
  int n_resp = 0;

  logic [EW-1:0] iq[$];
  logic [XLEN:0] rq[$];
  int   m_out = 0;
  logic m_rv = 1'b0;
  logic m_perr = 1'b0;

  apu_issue_queue_if #(.XLEN(XLEN), .NUM_OPERANDS(NOPS), .OP_W(OP_W), .FLAGS_W(FW)) apu_bus ();

  apu_issue_queue #(
    .DEPTH(DEPTH), .XLEN(XLEN), .VLEN(VLEN), .NUM_OPERANDS(NOPS),
    .OP_W(OP_W), .FLAGS_W(FW), .VL_W(VL_W)
  ) dut (
    .clk(clk), .reset(reset), .apu(apu_bus),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_operands(issue_operands), .issue_op(issue_op), .issue_flags(issue_flags),
    .done_i(done_i), .result_sel_i(result_sel_i), .sign_ext_i(sign_ext_i),
    .vl_i(vl_i), .vsew_i(vsew_i), .vs2_data_i(vs2_data_i)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1);
  end

  function automatic logic [XLEN-1:0] model_res(input logic sel, input logic sext,
                                                input logic [1:0] sew, input logic [VL_W-1:0] vl,
                                                input logic [VLEN-1:0] vs2);
    if (sew == 2'd3) return '0;
    if (!sel) return {27'b0, vl};
    case (sew)
      2'd0:    return sext ? {{24{vs2[7]}}, vs2[7:0]} : {24'h0, vs2[7:0]};
      2'd1:    return sext ? {{16{vs2[15]}}, vs2[15:0]} : {16'h0, vs2[15:0]};
      default: return vs2[31:0];
    endcase
  endfunction

  // Scoreboard monitor: checks grant, issue order and responses each cycle.
  initial begin
    logic acc, dv;
    logic [XLEN:0] r;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        iq.delete(); rq.delete();
        m_out = 0; m_rv = 1'b0; m_perr = 1'b0;
        n_checks++;
        if ({apu_bus.apu_gnt, issue_valid, apu_bus.apu_rvalid} !== 3'b000) begin
          n_fail++;
          $display("FAIL mon_reset_outputs: gnt/issue_valid/rvalid got %b want 000",
                   {apu_bus.apu_gnt, issue_valid, apu_bus.apu_rvalid});
        end
      end else begin
        acc = apu_bus.apu_req && (m_out < DEPTH);
        n_checks++;
        if (apu_bus.apu_gnt !== acc) begin
          n_fail++;
          $display("FAIL mon_gnt: got %b want %b (outstanding %0d)", apu_bus.apu_gnt, acc, m_out);
        end
        n_checks++;
        if (issue_valid !== (iq.size() != 0)) begin
          n_fail++;
          $display("FAIL mon_issue_valid: got %b want %b", issue_valid, (iq.size() != 0));
        end
        if (issue_valid && issue_ready && iq.size() != 0) begin
          e = iq.pop_front();
          n_checks++;
          if ({issue_operands, issue_op, issue_flags} !== e) begin
            n_fail++;
            $display("FAIL mon_issue_head: got %h want %h", {issue_operands, issue_op, issue_flags}, e);
          end
        end
        n_checks++;
        if (apu_bus.apu_rvalid !== m_rv || apu_bus.apu_flags_o[1] !== m_perr) begin
          n_fail++;
          $display("FAIL mon_rvalid_perr: rvalid got %b want %b, perr got %b want %b",
                   apu_bus.apu_rvalid, m_rv, apu_bus.apu_flags_o[1], m_perr);
        end
        if (apu_bus.apu_rvalid === 1'b1 && rq.size() != 0) begin
          r = rq.pop_front();
          n_resp++;
          $display("resp %0d: result=%h flags=%b", n_resp, apu_bus.apu_result, apu_bus.apu_flags_o);
          n_checks++;
          if (apu_bus.apu_result !== r[XLEN-1:0] ||
              apu_bus.apu_flags_o !== {3'b000, m_perr, r[XLEN]}) begin
            n_fail++;
            $display("FAIL mon_response: result got %h want %h, flags got %b want %b",
                     apu_bus.apu_result, r[XLEN-1:0], apu_bus.apu_flags_o, {3'b000, m_perr, r[XLEN]});
          end
        end
        if (acc) iq.push_back({apu_bus.apu_operands_i, apu_bus.apu_op, apu_bus.apu_flags_i});
        dv = done_i && (m_out != 0);
        if (dv) rq.push_back({(vsew_i == 2'd3),
                              model_res(result_sel_i, sign_ext_i, vsew_i, vl_i, vs2_data_i)});
        if (done_i && m_out == 0) m_perr = 1'b1;
        m_out = m_out + int'(acc) - int'(dv);
        m_rv = dv;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apu_bus.apu_req = 1'b0;
    apu_bus.apu_operands_i = '0;
    apu_bus.apu_op = '0;
    apu_bus.apu_flags_i = '0;
    issue_ready = 1'b0;
    done_i = 1'b0;
    result_sel_i = 1'b0;
    sign_ext_i = 1'b0;
    vl_i = '0;
    vsew_i = 2'd2;
    vs2_data_i = '0;
  endtask

  task automatic test_reset();
    idle();
    apu_bus.apu_req = 1'b1;
    @(posedge clk);
    #2;
    n_checks++;
    if ({apu_bus.apu_gnt, apu_bus.apu_rvalid, issue_valid} !== 3'b000 ||
        apu_bus.apu_result !== 32'h0 || apu_bus.apu_flags_o !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state: gnt/rvalid/iv got %b result %h flags %b want 000 0 0",
               {apu_bus.apu_gnt, apu_bus.apu_rvalid, issue_valid}, apu_bus.apu_result, apu_bus.apu_flags_o);
    end
    next_cycle();
    reset = 1'b0;
    apu_bus.apu_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_single();
    idle();
    apu_bus.apu_req = 1'b1;
    apu_bus.apu_operands_i = {32'h0, 32'h0, 32'h11};
    apu_bus.apu_op = 6'h05;
    issue_ready = 1'b1;
    #2;
    n_checks++;
    if (apu_bus.apu_gnt !== 1'b1) begin
      n_fail++; $display("FAIL single_gnt: got %b want 1", apu_bus.apu_gnt);
    end
    next_cycle();
    apu_bus.apu_req = 1'b0;
    #2;
    n_checks++;
    if (issue_valid !== 1'b1 || issue_operands[31:0] !== 32'h11 || issue_op !== 6'h05) begin
      n_fail++;
      $display("FAIL single_issue: valid %b op0 %h op %h want 1 11 05", issue_valid, issue_operands[31:0], issue_op);
    end
    next_cycle();
    done_i = 1'b1; result_sel_i = 1'b0; vl_i = 5'd16;
    next_cycle();
    done_i = 1'b0;
    #2;
    n_checks++;
    if (apu_bus.apu_rvalid !== 1'b1 || apu_bus.apu_result !== 32'h10) begin
      n_fail++; $display("FAIL single_result: rvalid %b result %h want 1 10", apu_bus.apu_rvalid, apu_bus.apu_result);
    end
    next_cycle();
    #2;
    n_checks++;
    if (apu_bus.apu_rvalid !== 1'b0 || apu_bus.apu_result !== 32'h10) begin
      n_fail++; $display("FAIL single_hold: rvalid %b result %h want 0 10", apu_bus.apu_rvalid, apu_bus.apu_result);
    end
    next_cycle();
  endtask

  task automatic test_full();
    idle();
    for (int i = 0; i < 5; i++) begin
      apu_bus.apu_req = 1'b1;
      apu_bus.apu_operands_i = {64'h0, 32'(i + 1)};
      #2;
      n_checks++;
      if (apu_bus.apu_gnt !== (i < 4)) begin
        n_fail++; $display("FAIL full_gnt_%0d: got %b want %b", i, apu_bus.apu_gnt, (i < 4));
      end
      next_cycle();
    end
    done_i = 1'b1; vl_i = 5'd1; issue_ready = 1'b1;
    #2;
    n_checks++;
    if (apu_bus.apu_gnt !== 1'b0) begin
      n_fail++; $display("FAIL full_gnt_at_done: got %b want 0", apu_bus.apu_gnt);
    end
    next_cycle();
    done_i = 1'b0; issue_ready = 1'b0;
    #2;
    n_checks++;
    if (apu_bus.apu_gnt !== 1'b1) begin
      n_fail++; $display("FAIL full_gnt_after_done: got %b want 1", apu_bus.apu_gnt);
    end
    next_cycle();
    apu_bus.apu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_ready = 1'b1; done_i = 1'b1; vl_i = 5'(i + 2);
      next_cycle();
    end
    idle();
    #2;
    n_checks++;
    if (apu_bus.apu_rvalid !== 1'b1 || apu_bus.apu_result !== 32'h5 || issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain: rvalid %b result %h iv %b want 1 5 0", apu_bus.apu_rvalid, apu_bus.apu_result, issue_valid);
    end
    next_cycle();
  endtask

  task automatic test_format();
    logic [1:0]   t_sew [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
    logic         t_sx  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0]  t_v   [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h1234_8001,
                                32'h1234_8001, 32'h8000_0001, 32'hAB00_007F};
    logic [31:0]  t_exp [6] = '{32'h0000_0080, 32'hFFFF_FF80, 32'hFFFF_8001,
                                32'h0000_8001, 32'h8000_0001, 32'h0000_007F};
    for (int i = 0; i < 6; i++) begin
      idle();
      apu_bus.apu_req = 1'b1; issue_ready = 1'b1;
      apu_bus.apu_operands_i = {64'h0, 32'(16 + i)};
      next_cycle();
      apu_bus.apu_req = 1'b0; issue_ready = 1'b0;
      done_i = 1'b1; result_sel_i = 1'b1; sign_ext_i = t_sx[i]; vsew_i = t_sew[i];
      vs2_data_i = {96'hA5A5_5A5A_DEAD_BEEF_0F0F_F0F0, t_v[i]};
      next_cycle();
      idle();
      #2;
      n_checks++;
      if (apu_bus.apu_rvalid !== 1'b1 || apu_bus.apu_result !== t_exp[i] || apu_bus.apu_flags_o !== 5'b0) begin
        n_fail++;
        $display("FAIL format_%0d: rvalid %b result %h flags %b want 1 %h 00000",
                 i, apu_bus.apu_rvalid, apu_bus.apu_result, apu_bus.apu_flags_o, t_exp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 2; i++) begin
      idle();
      apu_bus.apu_req = 1'b1; issue_ready = 1'b1;
      next_cycle();
      apu_bus.apu_req = 1'b0; issue_ready = 1'b0; done_i = 1'b1;
      if (i == 0) begin
        result_sel_i = 1'b1; sign_ext_i = 1'b1; vsew_i = 2'd3; vs2_data_i = 128'hFFFF_FFFF;
      end else begin
        result_sel_i = 1'b0; vsew_i = 2'd2; vl_i = 5'd7;
      end
      next_cycle();
      idle();
      #2;
      n_checks++;
      if (apu_bus.apu_result !== (i == 0 ? 32'h0 : 32'h7) ||
          apu_bus.apu_flags_o !== (i == 0 ? 5'b00001 : 5'b00000)) begin
        n_fail++;
        $display("FAIL illegal_sew_%0d: result %h flags %b want %h %b", i, apu_bus.apu_result,
                 apu_bus.apu_flags_o, (i == 0 ? 32'h0 : 32'h7), (i == 0 ? 5'b00001 : 5'b00000));
      end
      next_cycle();
    end
  endtask

  task automatic test_protocol();
    idle();
    done_i = 1'b1; vl_i = 5'd9;
    next_cycle();
    done_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_checks++;
      if (apu_bus.apu_rvalid !== 1'b0 || apu_bus.apu_flags_o !== 5'b00010) begin
        n_fail++;
        $display("FAIL proto_sticky_%0d: rvalid %b flags %b want 0 00010", i, apu_bus.apu_rvalid, apu_bus.apu_flags_o);
      end
      next_cycle();
    end
    apu_bus.apu_req = 1'b1; issue_ready = 1'b1;
    next_cycle();
    apu_bus.apu_req = 1'b0; issue_ready = 1'b0; done_i = 1'b1; vl_i = 5'd3;
    next_cycle();
    done_i = 1'b0;
    #2;
    n_checks++;
    if (apu_bus.apu_result !== 32'h3 || apu_bus.apu_flags_o !== 5'b00010) begin
      n_fail++; $display("FAIL proto_after_valid: result %h flags %b want 3 00010", apu_bus.apu_result, apu_bus.apu_flags_o);
    end
    next_cycle();
  endtask

  task automatic test_reset_flush();
    idle();
    apu_bus.apu_req = 1'b1;
    next_cycle();
    done_i = 1'b1; vl_i = 5'd9;
    next_cycle();
    done_i = 1'b0;
    #1;
    n_checks++;
    if (apu_bus.apu_rvalid !== 1'b1 || issue_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre: rvalid %b iv %b want 1 1", apu_bus.apu_rvalid, issue_valid);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({apu_bus.apu_gnt, apu_bus.apu_rvalid, issue_valid} !== 3'b000 || apu_bus.apu_flags_o !== 5'b0) begin
      n_fail++;
      $display("FAIL flush_immediate: gnt/rvalid/iv %b flags %b want 000 00000",
               {apu_bus.apu_gnt, apu_bus.apu_rvalid, issue_valid}, apu_bus.apu_flags_o);
    end
    next_cycle();
    reset = 1'b0;
    apu_bus.apu_req = 1'b0; issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_checks++;
      if (apu_bus.apu_rvalid !== 1'b0 || issue_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_stale_%0d: rvalid %b iv %b want 0 0", i, apu_bus.apu_rvalid, issue_valid);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 0; i < 3; i++) begin
      apu_bus.apu_req = 1'b1; apu_bus.apu_operands_i = {64'h0, 32'(256 + i)}; apu_bus.apu_op = 6'(i);
      next_cycle();
    end
    apu_bus.apu_req = 1'b0; issue_ready = 1'b1;
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      apu_bus.apu_req = 1'b1; issue_ready = 1'b1; done_i = 1'b1; vl_i = 5'(i + 10);
      apu_bus.apu_operands_i = {32'(i), 32'h0, 32'(512 + i)}; apu_bus.apu_flags_i = 15'(i * 3);
      #2;
      n_checks++;
      if (apu_bus.apu_gnt !== 1'b1 || issue_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_steady_%0d: gnt %b iv %b want 1 1", i, apu_bus.apu_gnt, issue_valid);
      end
      next_cycle();
    end
    issue_ready = 1'b0; done_i = 1'b0;
    next_cycle();
    apu_bus.apu_req = 1'b0;
    #2;
    apu_bus.apu_req = 1'b1;
    #1;
    n_checks++;
    if (apu_bus.apu_gnt !== 1'b0) begin
      n_fail++; $display("FAIL b2b_outstanding_kept: gnt %b want 0", apu_bus.apu_gnt);
    end
    apu_bus.apu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      issue_ready = 1'b1; done_i = 1'b1; vl_i = 5'(i);
    end
    next_cycle();
    idle();
    next_cycle();
    #2;
    n_checks++;
    if (issue_valid !== 1'b0 || iq.size() != 0 || rq.size() != 0) begin
      n_fail++; $display("FAIL b2b_drained: iv %b iq %0d rq %0d want 0 0 0", issue_valid, iq.size(), rq.size());
    end
    next_cycle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_full();
    test_format();
    test_illegal();
    test_protocol();
    test_reset_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
